// File: rtl/pio_input_poller.sv
// Autonomous poller for an input PIO: samples s1 data every PERIOD+3 cycles,
// debounces it, keeps sticky per-bit change flags and drives a maskable irq.
module pio_input_poller #(
  parameter int DATA_W  = 10,
  parameter int DIV_W   = 16,
  parameter int DEB_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  pio_address,
  output logic        pio_read,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  csr_address,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  output logic        irq
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEB_CNT);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  typedef enum logic [2:0] {IDLE, WAIT, ISSUE, CAPTURE, UPDATE} state_t;

  state_t             state;
  logic [DIV_W-1:0]   tick;
  logic [DIV_W-1:0]   period;
  logic [DATA_W-1:0]  mask;
  logic [DATA_W-1:0]  edge_flags;
  logic [DATA_W-1:0]  stable;
  logic [DATA_W-1:0]  cand;
  logic [DATA_W-1:0]  sample;
  logic [CNT_W-1:0]   match;

  logic               wr_period, wr_edge, wr_mask;
  logic [DIV_W-1:0]   new_period, per_eff;
  logic [CNT_W-1:0]   match_nxt;
  logic               commit;
  logic [DATA_W-1:0]  edge_set, edge_clr;
  logic               unused_bits;

  assign pio_address = 2'd0;
  assign unused_bits = ^{pio_readdata[31:DATA_W], csr_writedata[31:DIV_W]};

  assign wr_period  = csr_write && (csr_address == 2'd0);
  assign wr_edge    = csr_write && (csr_address == 2'd2);
  assign wr_mask    = csr_write && (csr_address == 2'd3);
  assign new_period = csr_writedata[DIV_W-1:0];
  // A PERIOD write takes effect on the same edge the FSM consults it.
  assign per_eff    = wr_period ? new_period : period;
  assign edge_clr   = wr_edge ? csr_writedata[DATA_W-1:0] : '0;

  always_comb begin
    if (sample != cand)     match_nxt = CNT_W'(1);
    else if (match >= DEB)  match_nxt = DEB;
    else                    match_nxt = match + CNT_W'(1);
    // New candidate is always the fresh sample, so compare it against STABLE.
    commit   = (state == UPDATE) && (match_nxt == DEB) && (sample != stable);
    edge_set = commit ? (stable ^ sample) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick     <= '0;
      pio_read <= 1'b0;
      sample   <= '0;
      cand     <= '0;
      match    <= '0;
      stable   <= '0;
    end else begin
      pio_read <= 1'b0;
      case (state)
        IDLE: if (per_eff != '0) begin
          tick  <= per_eff - ONE;
          state <= WAIT;
        end
        WAIT: begin
          if (per_eff == '0)   state <= IDLE;
          else if (wr_period)  tick  <= new_period - ONE;
          else if (tick == '0) begin
            state    <= ISSUE;
            pio_read <= 1'b1;
          end else             tick  <= tick - ONE;
        end
        ISSUE:   state <= CAPTURE;
        CAPTURE: begin
          sample <= pio_readdata[DATA_W-1:0];
          state  <= UPDATE;
        end
        UPDATE: begin
          cand  <= sample;
          match <= match_nxt;
          if (commit) stable <= sample;
          if (per_eff == '0) state <= IDLE;
          else begin
            tick  <= per_eff - ONE;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // CSR side: a commit setting a bit beats a same-cycle W1C of that bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period       <= '0;
      mask         <= '0;
      edge_flags   <= '0;
      irq          <= 1'b0;
      csr_readdata <= '0;
    end else begin
      if (wr_period) period <= new_period;
      if (wr_mask)   mask   <= csr_writedata[DATA_W-1:0];
      edge_flags <= (edge_flags & ~edge_clr) | edge_set;
      irq        <= |(edge_flags & mask);
      if (csr_read) begin
        case (csr_address)
          2'd0:    csr_readdata <= 32'(period);
          2'd1:    csr_readdata <= 32'(stable);
          2'd2:    csr_readdata <= 32'(edge_flags);
          default: csr_readdata <= 32'(mask);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_input_poller.sv
// Directed bench: CSR reads go through a scoreboard queue checked by a monitor;
// poll spacing, debounce, W1C race, stop-on-zero and mid-run reset are covered.
module tb_pio_input_poller;

  localparam int DATA_W = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pio_address;
  logic        pio_read;
  logic [31:0] pio_readdata;
  logic [1:0]  csr_address;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        irq;
  logic [DATA_W-1:0] in_port;

  pio_input_poller #(.DATA_W(DATA_W), .DIV_W(16), .DEB_CNT(4)) dut (
    .clk(clk), .reset(reset),
    .pio_address(pio_address), .pio_read(pio_read), .pio_readdata(pio_readdata),
    .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_read(csr_read), .csr_readdata(csr_readdata), .irq(irq)
  );

  // Upper PIO bits carry junk that must be ignored.
  assign pio_readdata = {22'h2AAAAA, in_port};

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_issue = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t mon_e;
  logic    rd_vld;

  always @(posedge clk or posedge reset)
    if (reset) rd_vld <= 1'b0;
    else       rd_vld <= csr_read;

  always @(negedge clk) begin
    if (rd_vld) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL csr_rd_unexpected got=%h", csr_readdata);
      end else begin
        mon_e = sb.pop_front();
        if (csr_readdata !== mon_e.exp) begin
          failures++;
          $display("FAIL csr_rd[%0d] got=%h exp=%h", mon_e.addr, csr_readdata, mon_e.exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_write = 1'b1; csr_address = a; csr_writedata = d;
    step(1);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp);
    rd_exp_t e;
    e.addr = a; e.exp = exp;
    sb.push_back(e);
    csr_read = 1'b1; csr_address = a;
    step(1);
    csr_read = 1'b0;
  endtask

  // Returns positioned in the CAPTURE cycle following a pio_read pulse.
  task automatic wait_issue();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (pio_read) found = 1'b1;
      else          step(1);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_issue got=timeout exp=pio_read");
    end else begin
      t_issue = cyc;
      step(1);
    end
  endtask

  // One full sample; returns in the first WAIT cycle after UPDATE.
  task automatic sample();
    wait_issue();
    step(2);
  endtask

  task automatic quiet(input int n, input string nm);
    int p;
    p = 0;
    repeat (n) begin
      if (pio_read) p++;
      step(1);
    end
    chk(nm, 32'(p), 32'd0);
  endtask

  initial begin
    int t_prev;
    reset = 1'b1;
    csr_address = '0; csr_write = 1'b0; csr_writedata = '0; csr_read = 1'b0;
    in_port = '0;
    step(3);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_pio_read", 32'(pio_read), 32'd0);
    chk("rst_pio_address", 32'(pio_address), 32'd0);
    chk("rst_readdata", csr_readdata, 32'd0);
    reset = 1'b0;
    step(1);
    csr_rd(2'd0, 32'h0); csr_rd(2'd1, 32'h0); csr_rd(2'd2, 32'h0); csr_rd(2'd3, 32'h0);
    quiet(20, "idle_no_poll");

    // PERIOD=5: one sample every 8 cycles, all zero input
    csr_wr(2'd0, 32'd5);
    sample(); t_prev = t_issue;
    sample(); chk("spacing_a", 32'(t_issue - t_prev), 32'd8); t_prev = t_issue;
    sample(); chk("spacing_b", 32'(t_issue - t_prev), 32'd8);
    sample();
    csr_rd(2'd1, 32'h0); csr_rd(2'd2, 32'h0);

    // step to 0x2A5: commit on the 4th sample, irq one cycle later
    csr_wr(2'd3, 32'h001);
    in_port = 10'h2A5;
    sample(); sample(); sample();
    csr_rd(2'd1, 32'h0);
    sample();
    chk("irq_at_commit", 32'(irq), 32'd0);
    step(1);
    chk("irq_after_commit", 32'(irq), 32'd1);
    csr_rd(2'd1, 32'h2A5); csr_rd(2'd2, 32'h2A5);

    // back to zero baseline, clear EDGE, then a 2-sample glitch
    in_port = 10'h000;
    sample(); sample(); sample(); sample();
    csr_rd(2'd1, 32'h0); csr_rd(2'd2, 32'h2A5);
    csr_wr(2'd2, 32'h3FF);
    csr_rd(2'd2, 32'h0);
    chk("irq_cleared", 32'(irq), 32'd0);
    in_port = 10'h001;
    sample(); sample();
    chk("glitch_irq", 32'(irq), 32'd0);
    csr_rd(2'd1, 32'h0);
    in_port = 10'h000;
    sample(); sample(); sample(); sample();
    csr_rd(2'd1, 32'h0); csr_rd(2'd2, 32'h0);
    chk("glitch_irq_end", 32'(irq), 32'd0);

    // W1C of all bits in the same cycle as a commit setting bit 3
    in_port = 10'h008;
    sample(); sample(); sample();
    wait_issue(); step(1);
    csr_wr(2'd2, 32'h3FF);
    csr_rd(2'd2, 32'h008);
    chk("race_irq_mask1", 32'(irq), 32'd0);
    csr_wr(2'd3, 32'h008);
    chk("mask_irq_lag", 32'(irq), 32'd0);
    step(1);
    chk("mask_irq", 32'(irq), 32'd1);
    csr_rd(2'd1, 32'h008);

    // PERIOD=0 written during CAPTURE: last sample still commits
    in_port = 10'h000;
    sample(); sample(); sample();
    wait_issue();
    csr_wr(2'd0, 32'd0);
    step(1);
    csr_rd(2'd1, 32'h0); csr_rd(2'd0, 32'h0); csr_rd(2'd2, 32'h008);
    quiet(40, "no_poll_after_stop");

    // build EDGE=0x0F0 then reset mid-WAIT
    csr_wr(2'd2, 32'h3FF);
    csr_rd(2'd2, 32'h0);
    in_port = 10'h0F0;
    csr_wr(2'd0, 32'd5);
    sample(); sample(); sample(); sample();
    csr_wr(2'd3, 32'h0F0);
    csr_rd(2'd2, 32'h0F0);
    chk("pre_reset_irq", 32'(irq), 32'd1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("async_rst_irq", 32'(irq), 32'd0);
    chk("async_rst_pio_read", 32'(pio_read), 32'd0);
    chk("async_rst_readdata", csr_readdata, 32'd0);
    step(2);
    reset = 1'b0;
    csr_rd(2'd0, 32'h0); csr_rd(2'd1, 32'h0); csr_rd(2'd2, 32'h0); csr_rd(2'd3, 32'h0);
    quiet(30, "no_poll_after_reset");
    csr_wr(2'd0, 32'd3);
    sample(); t_prev = t_issue;
    sample(); chk("spacing_p3", 32'(t_issue - t_prev), 32'd6);
    step(2);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
